// File: rtl/busca_alvo_pkg.sv
// busca_alvo_pkg: state codes, quadrant bit positions and index helpers shared by busca_alvo_anel
package busca_alvo_pkg;
  typedef logic [1:0] estado_t;
  localparam estado_t OCIOSO = 2'd0;
  localparam estado_t VARRE = 2'd1;
  localparam estado_t FIM = 2'd2;
  localparam int Q_DF = 3;
  localparam int Q_EF = 2;
  localparam int Q_DT = 1;
  localparam int Q_ET = 0;
  function automatic int indiceCelula(input int x, input int y, input int tamanho);
    return x + y * tamanho;
  endfunction
  // Offset (0,0) is never scheduled, so the last branch only ever sees dx<0,dy<=0
  function automatic logic [1:0] quadrante(input int dx, input int dy);
    return (dx > 0 && dy >= 0) ? 2'(Q_DF) :
           (dx <= 0 && dy > 0) ? 2'(Q_EF) :
           (dx >= 0 && dy < 0) ? 2'(Q_DT) : 2'(Q_ET);
  endfunction
endpackage

// File: rtl/busca_alvo_anel_percorre_anel.sv
// percorre_anel: walks Chebyshev rings counter-clockwise, one offset per advance, from (r,0)
module percorre_anel
  import busca_alvo_pkg::*;
#(
  parameter int tamanhoDistancia = 8,
  parameter int raioMaximo = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic inicia,
  input  logic avanca,
  output logic signed [tamanhoDistancia:0] dx,
  output logic signed [tamanhoDistancia:0] dy,
  output logic [tamanhoDistancia-1:0] r,
  output logic ultimo
);
  localparam int W = tamanhoDistancia;
  logic [2:0] seg;
  logic [W:0] passo;
  logic [W:0] comp;
  logic fim_seg;
  logic signed [W:0] rs;
  logic signed [W:0] ps;
  // Segments 0 and 4 are the half sides on the +x edge, the other three are full sides
  always_comb begin
    rs = signed'({1'b0, r});
    ps = signed'(passo);
    comp = (seg == 3'd0 || seg == 3'd4) ? {1'b0, r} : {r, 1'b0};
    fim_seg = passo == comp - 1'b1;
    ultimo = seg == 3'd4 && fim_seg && r == W'(raioMaximo);
    dx = seg == 3'd0 ? rs : seg == 3'd1 ? rs - ps : seg == 3'd2 ? -rs : seg == 3'd3 ? ps - rs : rs;
    dy = seg == 3'd0 ? ps : seg == 3'd1 ? rs : seg == 3'd2 ? rs - ps : seg == 3'd3 ? -rs : ps - rs;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r <= '0;
      seg <= '0;
      passo <= '0;
    end else if (inicia) begin
      r <= W'(1);
      seg <= '0;
      passo <= '0;
    end else if (avanca) begin
      passo <= fim_seg ? '0 : passo + 1'b1;
      seg <= !fim_seg ? seg : seg == 3'd4 ? 3'd0 : seg + 3'd1;
      r <= (fim_seg && seg == 3'd4) ? r + 1'b1 : r;
    end
endmodule

// File: rtl/busca_alvo_anel.sv
// busca_alvo_anel: ring-by-ring nearest target search over a flattened occupancy grid.
// Define MALHA_SNAPSHOT_EN to copy the grid at start instead of reading it live.
module busca_alvo_anel
  import busca_alvo_pkg::*;
#(
  parameter int TamanhoMalha = 8,
  parameter int tamanhoDistancia = 8,
  parameter int larguraCelula = 2,
  parameter int raioMaximo = TamanhoMalha - 1
) (
  input  logic clock,
  input  logic reset,
  input  logic novoDado,
  input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
  input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
  input  logic [larguraCelula-1:0] valorAlvo,
  input  logic [3:0] enable,
  input  logic [larguraCelula-1:0] malha [TamanhoMalha*TamanhoMalha],
  output logic ocupado,
  output logic operacaoFinalizada,
  output logic encontrado,
  output logic [tamanhoDistancia-1:0] destinoX,
  output logic [tamanhoDistancia-1:0] destinoY,
  output logic [tamanhoDistancia-1:0] distancia
);
  localparam int W = tamanhoDistancia;
  localparam int NC = TamanhoMalha * TamanhoMalha;
  localparam int IW = $clog2(NC);
  estado_t estado;
  logic [W-1:0] px;
  logic [W-1:0] py;
  logic [larguraCelula-1:0] alvo;
  logic [3:0] en;
  logic signed [W:0] dx;
  logic signed [W:0] dy;
  logic signed [W:0] cx;
  logic signed [W:0] cy;
  logic [W-1:0] r;
  logic ultimo;
  logic aceita;
  logic varre;
  logic valido;
  logic aborta;
  logic acerto;
  logic [IW-1:0] idx;
  logic [larguraCelula-1:0] celula;
  percorre_anel #(
    .tamanhoDistancia(tamanhoDistancia),
    .raioMaximo(raioMaximo)
  ) u_anel (
    .clock(clock),
    .reset(reset),
    .inicia(aceita),
    .avanca(varre),
    .dx(dx),
    .dy(dy),
    .r(r),
    .ultimo(ultimo)
  );
`ifdef MALHA_SNAPSHOT_EN
  logic [larguraCelula-1:0] copia [NC];
  always_ff @(posedge clock)
    if (aceita) copia <= malha;
  assign celula = copia[idx];
`else
  assign celula = malha[idx];
`endif
  // A captured position outside the grid would overflow the candidate sum, so it aborts first
  always_comb begin
    aceita = estado == OCIOSO && novoDado;
    varre = estado == VARRE;
    ocupado = estado == VARRE || estado == FIM;
    operacaoFinalizada = estado == FIM;
    cx = signed'({1'b0, px}) + dx;
    cy = signed'({1'b0, py}) + dy;
    valido = !cx[W] && !cy[W] && cx[W-1:0] < W'(TamanhoMalha) && cy[W-1:0] < W'(TamanhoMalha);
    idx = valido ? IW'(indiceCelula(int'(cx), int'(cy), TamanhoMalha)) : '0;
    aborta = en == 4'd0 || px >= W'(TamanhoMalha) || py >= W'(TamanhoMalha);
    acerto = !aborta && valido && en[quadrante(int'(dx), int'(dy))] && celula == alvo;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado <= OCIOSO;
      px <= '0;
      py <= '0;
      alvo <= '0;
      en <= '0;
      encontrado <= 1'b0;
      destinoX <= '0;
      destinoY <= '0;
      distancia <= '0;
    end else if (aceita) begin
      estado <= VARRE;
      px <= posicaoAtualnoEixoX;
      py <= posicaoAtualnoEixoY;
      alvo <= valorAlvo;
      en <= enable;
      encontrado <= 1'b0;
      destinoX <= posicaoAtualnoEixoX;
      destinoY <= posicaoAtualnoEixoY;
      distancia <= '0;
    end else if (varre) begin
      estado <= (aborta || acerto || ultimo) ? FIM : VARRE;
      if (acerto) begin
        encontrado <= 1'b1;
        destinoX <= cx[W-1:0];
        destinoY <= cy[W-1:0];
        distancia <= r;
      end
    end else begin
      estado <= OCIOSO;
    end
endmodule
